// File: rtl/snn_pkg.sv
// Shared SNN constants and the step-scheduler types.
// The scheduler FSM encodings are plain constants so older tools can use them.
package snn_pkg;

  localparam int unsigned T            = 4;
  localparam int unsigned N            = 4;
  localparam int unsigned NN           = 1;
  localparam int unsigned ALPHA        = 8;
  localparam int unsigned SCHED_SETTLE = 8;

  typedef logic [2:0] sched_state_t;

  localparam sched_state_t StIdle   = 3'd0;
  localparam sched_state_t StStep   = 3'd1;
  localparam sched_state_t StSettle = 3'd2;
  localparam sched_state_t StDrain  = 3'd3;
  localparam sched_state_t StNext   = 3'd4;

  typedef struct packed {
    logic [$clog2(T)-1:0] block;
    logic [$clog2(N)-1:0] neuron;
  } spike_sel_t;

endpackage

// File: rtl/snn_readout_gate.sv
// Readout gate: forwards one drain of Beats spike-count beats, generating tlast
// locally and flagging any beat whose upstream tlast disagrees with it.
module snn_readout_gate #(
  parameter int unsigned Beats = 16,
  parameter int unsigned DataW = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             s_tvalid_i,
  output logic             s_tready_o,
  input  logic [DataW-1:0] s_tdata_i,
  input  logic             s_tlast_i,
  output logic             m_tvalid_o,
  input  logic             m_tready_i,
  output logic [DataW-1:0] m_tdata_o,
  output logic             m_tlast_o,
  output logic             beat_done_o,
  output logic             tlast_err_o
);

  localparam int unsigned CntW = (Beats > 1) ? $clog2(Beats) : 1;
  localparam logic [CntW-1:0] LastBeat = CntW'(Beats - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            fire;
  logic            at_last;

  assign at_last = (cnt_q == LastBeat);

  always_comb begin
    s_tready_o  = en_i & m_tready_i;
    m_tvalid_o  = en_i & s_tvalid_i;
    m_tdata_o   = s_tdata_i;
    m_tlast_o   = at_last;
    fire        = en_i & s_tvalid_i & m_tready_i;
    beat_done_o = fire & at_last;
    tlast_err_o = fire & (s_tlast_i != at_last);
    cnt_d       = cnt_q;
    if (fire) begin
      cnt_d = at_last ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/snn_step_scheduler.sv
// Runs project_top through num_steps SNN time steps: time_step window with
// forced-spike injection, a settle gap, then a T*N-beat readout drain.
module snn_step_scheduler
  import snn_pkg::*;
#(
  parameter int unsigned T      = snn_pkg::T,
  parameter int unsigned N      = snn_pkg::N,
  parameter int unsigned NN     = snn_pkg::NN,
  parameter int unsigned ALPHA  = snn_pkg::ALPHA,
  parameter int unsigned SETTLE = snn_pkg::SCHED_SETTLE,
  parameter int unsigned SW     = 16
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 start,
  input  logic [SW-1:0]        num_steps,
  output logic                 busy,
  output logic                 done,
  output logic                 err_tlast,
  input  logic                 inj_valid,
  output logic                 inj_ready,
  input  logic [$clog2(T)-1:0] inj_block,
  input  logic [$clog2(N)-1:0] inj_neuron,
  output logic                 time_step,
  output logic                 force_spike_en,
  output logic [$clog2(T)-1:0] force_spike_block_select,
  output logic [$clog2(N)-1:0] force_spike_neuron_select,
  input  logic                 s_tvalid,
  output logic                 s_tready,
  input  logic [8*NN-1:0]      s_tdata,
  input  logic                 s_tlast,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic [8*NN-1:0]      m_tdata,
  output logic                 m_tlast
);

  localparam int unsigned CW = 16;
  localparam logic [CW-1:0] AlphaLast  = CW'(ALPHA - 1);
  localparam logic [CW-1:0] SettleLast = CW'(SETTLE - 1);

  sched_state_t    state_q, state_d;
  logic [SW-1:0]   steps_q, steps_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            ts_q, ts_d;
  logic            fen_q, fen_d;
  logic            rdy_q, rdy_d;
  spike_sel_t      sel_q, sel_d;
  logic            accept;
  logic            drain_en;
  logic            beat_done;
  logic            tlast_err;

  assign drain_en = (state_q == StDrain);
  assign accept   = inj_valid & rdy_q;

  snn_readout_gate #(
    .Beats (T * N),
    .DataW (8 * NN)
  ) u_gate (
    .clk_i       (aclk),
    .rst_ni      (aresetn),
    .en_i        (drain_en),
    .s_tvalid_i  (s_tvalid),
    .s_tready_o  (s_tready),
    .s_tdata_i   (s_tdata),
    .s_tlast_i   (s_tlast),
    .m_tvalid_o  (m_tvalid),
    .m_tready_i  (m_tready),
    .m_tdata_o   (m_tdata),
    .m_tlast_o   (m_tlast),
    .beat_done_o (beat_done),
    .tlast_err_o (tlast_err)
  );

  always_comb begin
    state_d = state_q;
    steps_d = steps_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    sel_d   = sel_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          err_d   = 1'b0;
          steps_d = num_steps;
          if (num_steps == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = StStep;
            busy_d  = 1'b1;
            cnt_d   = '0;
          end
        end
      end
      StStep: begin
        if (accept) begin
          sel_d.block  = inj_block;
          sel_d.neuron = inj_neuron;
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == AlphaLast) begin
          cnt_d   = '0;
          state_d = (SETTLE == 0) ? StDrain : StSettle;
        end
      end
      StSettle: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SettleLast) begin
          cnt_d   = '0;
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (tlast_err) begin
          err_d = 1'b1;
        end
        if (beat_done) begin
          state_d = StNext;
        end
      end
      StNext: begin
        steps_d = steps_q - 1'b1;
        cnt_d   = '0;
        if (steps_q == SW'(1)) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end else begin
          state_d = StStep;
        end
      end
      default: state_d = StIdle;
    endcase
    ts_d  = (state_d == StStep);
    rdy_d = (state_d == StStep);
    // An accept on the last window cycle still gets its one-cycle force pulse.
    fen_d = accept;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= StIdle;
      steps_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ts_q    <= 1'b0;
      fen_q   <= 1'b0;
      rdy_q   <= 1'b0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      steps_q <= steps_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ts_q    <= ts_d;
      fen_q   <= fen_d;
      rdy_q   <= rdy_d;
      sel_q   <= sel_d;
    end
  end

  assign busy                      = busy_q;
  assign done                      = done_q;
  assign err_tlast                 = err_q;
  assign time_step                 = ts_q;
  assign force_spike_en            = fen_q;
  assign inj_ready                 = rdy_q;
  assign force_spike_block_select  = sel_q.block;
  assign force_spike_neuron_select = sel_q.neuron;

endmodule

// File: tb/tb_snn_step_scheduler.sv
// Table-driven bench for snn_step_scheduler with a small source model for the
// DUT readout stream and a monitor that tallies per-run observations.
module tb_snn_step_scheduler;

  localparam int unsigned ALPHA  = 8;
  localparam int unsigned SETTLE = 4;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        start;
  logic [15:0] num_steps;
  logic        busy, done, err_tlast;
  logic        inj_valid, inj_ready;
  logic [1:0]  inj_block, inj_neuron;
  logic        time_step, force_spike_en;
  logic [1:0]  fs_block, fs_neuron;
  logic        s_tvalid, s_tready, s_tlast;
  logic [7:0]  s_tdata;
  logic        m_tvalid, m_tready, m_tlast;
  logic [7:0]  m_tdata;

  snn_step_scheduler #(
    .T      (4),
    .N      (4),
    .NN     (1),
    .ALPHA  (ALPHA),
    .SETTLE (SETTLE),
    .SW     (16)
  ) dut (
    .aclk                      (aclk),
    .aresetn                   (aresetn),
    .start                     (start),
    .num_steps                 (num_steps),
    .busy                      (busy),
    .done                      (done),
    .err_tlast                 (err_tlast),
    .inj_valid                 (inj_valid),
    .inj_ready                 (inj_ready),
    .inj_block                 (inj_block),
    .inj_neuron                (inj_neuron),
    .time_step                 (time_step),
    .force_spike_en            (force_spike_en),
    .force_spike_block_select  (fs_block),
    .force_spike_neuron_select (fs_neuron),
    .s_tvalid                  (s_tvalid),
    .s_tready                  (s_tready),
    .s_tdata                   (s_tdata),
    .s_tlast                   (s_tlast),
    .m_tvalid                  (m_tvalid),
    .m_tready                  (m_tready),
    .m_tdata                   (m_tdata),
    .m_tlast                   (m_tlast)
  );

  always #5 aclk = ~aclk;

  int n_vec = 0;
  int n_fail = 0;

  // Source / injection model state
  int src_seq = 0, src_idx = 0, inj_left = 0, inj_k = 0;
  bit s_fire_n = 0, inj_adv = 0, tog_mode = 0, bad_mode = 0;

  // Monitor tallies
  int cyc = 0, ts_cnt, force_cnt, beats, tlast_cnt, done_cnt, mon_err, step_idx;
  int acc_per_step[8];
  int st_cyc, done_cyc, ts_first, fb_cyc;
  int chk_seq = 0, chk_idx = 0;
  bit busy_seen, ts_prev = 0, acc_prev = 0;
  logic [3:0] exp_sel = '0;

  typedef struct {
    int steps; int n_inj; int tog; int bad;
    int ts; int force_n; int beats; int tlasts; int lat; int fb;
    int acc1; int acc2; int acc3; int err;
  } vec_t;

  vec_t vecs[6];

  function automatic void chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  // Driver: inputs change 1 time unit after the active edge.
  initial begin
    m_tready = 1'b1; s_tvalid = 1'b1; s_tdata = '0; s_tlast = 1'b0;
    inj_valid = 1'b0; inj_block = '0; inj_neuron = '0;
    forever begin
      @(posedge aclk); #1;
      if (!aresetn) begin
        src_seq = 0; src_idx = 0;
      end else if (s_fire_n) begin
        src_seq++;
        src_idx = (src_idx == 15) ? 0 : src_idx + 1;
      end
      if (inj_adv) begin
        inj_left--; inj_k++;
      end
      m_tready   = tog_mode ? ~m_tready : 1'b1;
      s_tdata    = src_seq[7:0];
      s_tlast    = bad_mode ? (src_idx == 7) : (src_idx == 15);
      inj_valid  = (inj_left > 0);
      inj_block  = 2'(inj_k % 4);
      inj_neuron = 2'((inj_k + 1) % 4);
    end
  end

  // Monitor: samples on the falling edge, where everything is settled.
  always @(negedge aclk) begin
    bit acc, m_fire;
    cyc++;
    if (!aresetn) begin
      chk_seq = 0; chk_idx = 0; acc_prev = 0; ts_prev = 0;
    end
    s_fire_n = s_tvalid && s_tready;
    m_fire   = m_tvalid && m_tready;
    acc      = inj_valid && inj_ready;
    inj_adv  = acc;
    if (start && st_cyc < 0) st_cyc = cyc;
    if (time_step) begin
      ts_cnt++;
      if (ts_first < 0) ts_first = cyc;
      if (!ts_prev && step_idx < 7) step_idx++;
    end
    ts_prev = time_step;
    if (force_spike_en) begin
      force_cnt++;
      if ({fs_block, fs_neuron} != exp_sel) mon_err++;
    end
    if (force_spike_en != acc_prev) mon_err++;
    acc_prev = acc;
    if (acc) begin
      acc_per_step[step_idx]++;
      exp_sel = {inj_block, inj_neuron};
    end
    if (m_fire) begin
      beats++;
      if (fb_cyc < 0) fb_cyc = cyc;
      if (m_tdata != chk_seq[7:0]) mon_err++;
      if (m_tlast != (chk_idx == 15)) mon_err++;
      if (m_tlast) tlast_cnt++;
      chk_seq++;
      chk_idx = (chk_idx == 15) ? 0 : chk_idx + 1;
    end
    if (done) begin
      done_cnt++;
      if (done_cyc < 0) done_cyc = cyc;
      if (busy) mon_err++;
    end
    if (busy) busy_seen = 1;
  end

  task automatic clear_tallies();
    ts_cnt = 0; force_cnt = 0; beats = 0; tlast_cnt = 0; done_cnt = 0;
    mon_err = 0; step_idx = 0; busy_seen = 0;
    st_cyc = -1; done_cyc = -1; ts_first = -1; fb_cyc = -1;
    for (int i = 0; i < 8; i++) acc_per_step[i] = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " busy"}, int'(busy), 0);
    chk({tag, " done"}, int'(done), 0);
    chk({tag, " err_tlast"}, int'(err_tlast), 0);
    chk({tag, " time_step"}, int'(time_step), 0);
    chk({tag, " force_en"}, int'(force_spike_en), 0);
    chk({tag, " inj_ready"}, int'(inj_ready), 0);
    chk({tag, " s_tready"}, int'(s_tready), 0);
    chk({tag, " m_tvalid"}, int'(m_tvalid), 0);
    chk({tag, " m_tlast"}, int'(m_tlast), 0);
    chk({tag, " selects"}, int'({fs_block, fs_neuron}), 0);
  endtask

  task automatic launch(input int steps, input int n_inj, input int tog, input int bad);
    @(posedge aclk); #1;
    clear_tallies();
    inj_left = n_inj; inj_k = 0;
    tog_mode = (tog != 0); bad_mode = (bad != 0);
    num_steps = 16'(steps);
    start = 1'b1;
    @(posedge aclk); #1;
    start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int i;
    launch(v.steps, v.n_inj, v.tog, v.bad);
    for (i = 0; i < 3000 && done_cnt == 0; i++) @(negedge aclk);
    if (done_cnt == 0) chk({nm, " done_timeout"}, 0, 1);
    repeat (4) @(negedge aclk);
    chk({nm, " time_step_cycles"}, ts_cnt, v.ts);
    chk({nm, " force_pulses"}, force_cnt, v.force_n);
    chk({nm, " beats"}, beats, v.beats);
    chk({nm, " tlast_count"}, tlast_cnt, v.tlasts);
    chk({nm, " done_pulses"}, done_cnt, 1);
    chk({nm, " err_tlast"}, int'(err_tlast), v.err);
    chk({nm, " stream_order_sel"}, mon_err, 0);
    chk({nm, " acc_step1"}, acc_per_step[1], v.acc1);
    chk({nm, " acc_step2"}, acc_per_step[2], v.acc2);
    chk({nm, " acc_step3"}, acc_per_step[3], v.acc3);
    chk({nm, " busy_seen"}, int'(busy_seen), (v.steps != 0) ? 1 : 0);
    if (v.lat >= 0) chk({nm, " start_to_done"}, done_cyc - st_cyc, v.lat);
    if (v.fb >= 0) chk({nm, " step_to_beat"}, fb_cyc - ts_first, v.fb);
  endtask

  initial begin
    int i;
    // steps inj tog bad | ts force beats tlasts lat fb | acc1..3 | err
    vecs[0] = '{1, 1, 0, 0,  8,  1, 16, 1, 30, 12, 1, 0, 0, 0};
    vecs[1] = '{3, 10, 0, 0, 24, 10, 48, 3, 88, 12, 8, 2, 0, 0};
    vecs[2] = '{0, 0, 0, 0,  0,  0,  0, 0,  1, -1, 0, 0, 0, 0};
    vecs[3] = '{1, 0, 1, 0,  8,  0, 16, 1, -1, -1, 0, 0, 0, 0};
    vecs[4] = '{1, 0, 0, 1,  8,  0, 16, 1, 30, 12, 0, 0, 0, 1};
    vecs[5] = '{1, 0, 0, 0,  8,  0, 16, 1, 30, 12, 0, 0, 0, 0};

    aresetn = 1'b0; start = 1'b0; num_steps = '0;
    clear_tallies();
    repeat (3) @(negedge aclk);
    check_reset_outputs("por");
    @(posedge aclk); #1;
    aresetn = 1'b1;

    for (i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset in the middle of a drain, after five beats have gone downstream.
    launch(1, 0, 0, 0);
    for (i = 0; i < 3000 && beats < 5; i++) @(negedge aclk);
    chk("midrst reached_beat5", beats, 5);
    #2;
    aresetn = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(negedge aclk);
    @(posedge aclk); #1;
    aresetn = 1'b1;
    run_vec(vecs[5], "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
